led_blink_arbiter: RTL and testbench
====================================

Name: led_blink_arbiter

Overview:
- Shares one status LED between several requesters. Each requester asks for a burst of N blinks.
- A round-robin arbiter grants the LED to one requester at a time.
- An FSM sequences ON/OFF/GAP phases using a tick prescaler derived from the system clock.
- Sits beside heart-beat/status logic at board top level and drives the physical LED pin.

Parameters:
- CLK_VALUE, 100000000, input clock frequency in Hz.
- TICK_HZ, 10, tick rate; TICK_DIV = CLK_VALUE / TICK_HZ clocks per tick, must be ≥ 2.
- REQ_NUM, 4, number of requesters, ≥ 2.
- CNT_WIDTH, 4, width of each blink-count field.
- ON_TICKS, 2, ticks LED is high per blink, ≥ 1.
- OFF_TICKS, 2, ticks LED is low between blinks, ≥ 1.
- GAP_TICKS, 6, trailing low ticks after the last blink, ≥ 1.

Ports:
- clk_i  input  1  system clock.
- arst_i  input  1  asynchronous active-high reset.
- req_i  input  REQ_NUM  per-requester request level.
- blink_cnt_i  input  REQ_NUM*CNT_WIDTH  blink count; requester k uses bits [k*CNT_WIDTH +: CNT_WIDTH].
- grant_o  output  REQ_NUM  one-hot grant, held for the whole sequence.
- done_o  output  REQ_NUM  one-cycle one-hot completion pulse.
- busy_o  output  1  high while any grant is active.
- led_o  output  1  LED drive, active high.

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-high (arst_i); the clock is clk_i.
  - While arst_i is high: FSM=IDLE, grant_o=0, done_o=0, busy_o=0, led_o=0, prescaler=0, tick counter=0, remaining=0.
  - Round-robin pointer last=REQ_NUM-1, so req 0 has first priority.
- All outputs are registered.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - A tick is the cycle with prescaler==TICK_DIV-1.
  - Prescaler and tick counter are both cleared on every FSM state change. Each phase therefore lasts exactly X_TICKS*TICK_DIV cycles.
- FSM states: IDLE, ON, OFF, GAP.
- IDLE:
  - Scan req_i from last+1 upward, with modulo REQ_NUM wrap; the first set bit wins.
  - At that edge: grant_o<=onehot(k), last<=k, busy_o<=1, remaining<=blink_cnt_i slice k.
  - If the slice ≠ 0: state<=ON, led_o<=1.
  - If the slice = 0: state<=GAP, led_o<=0; the sequence is a plain gap, then done.
  - Latency: req sampled high at edge n, so grant_o, busy_o and led_o are high after edge n.
- ON:
  - led_o=1 for ON_TICKS ticks.
  - At the final tick: remaining<=remaining-1, led_o<=0, state<=OFF.
- OFF:
  - led_o=0 for OFF_TICKS ticks.
  - At the final tick: if remaining≠0, go to ON with led_o<=1; otherwise go to GAP.
- GAP:
  - led_o=0 for GAP_TICKS ticks.
  - At the final tick: grant_o<=0, busy_o<=0, done_o<=onehot(k) for one cycle, state<=IDLE.
- Sequence length: grant duration = (N*(ON_TICKS+OFF_TICKS)+GAP_TICKS)*TICK_DIV cycles.
- Arbitration gaps: the earliest next grant is one cycle after done_o (at least one IDLE cycle).
- Request changes during a sequence:
  - req_i deasserting mid-sequence is ignored; the sequence completes and done_o still pulses.
  - blink_cnt_i changes after the grant edge are ignored (latched).
- Requesters: hold req_i until done_o; drop req_i in the done_o cycle to avoid a re-request.
  - A requester that keeps req_i high is re-granted only after all other pending requesters (round-robin fairness).
- Simultaneous requests in IDLE: exactly one grant, chosen by the rotating priority.
- Reset mid-sequence: all state returns to reset values immediately. No done_o is issued.
- Width/overflow rules:
  - remaining is CNT_WIDTH bits and never underflows (decrements only from ≥1).
  - Prescaler width is $clog2(TICK_DIV); tick counter width is $clog2(max(ON_TICKS,OFF_TICKS,GAP_TICKS)+1).

Optional Feature:
- Macro LED_BLINK_ARBITER_IDLE_BEAT_EN.
- Defined: in IDLE, led_o toggles every GAP_TICKS ticks from a free-running idle tick count. This gives an alive indication. Entering ON forces led_o=1 regardless of the current idle phase.
- Undefined: led_o is held 0 in IDLE.

Test Plan:
All scenarios use CLK_VALUE=100, TICK_HZ=10 (TICK_DIV=10), ON_TICKS=1, OFF_TICKS=1, GAP_TICKS=2, REQ_NUM=4, CNT_WIDTH=4.
- Single request: req_i=0001, cnt0=3, held until done.
  - grant_o=0001 for 80 cycles; led_o high 10/low 10 three times, then low 20.
  - done_o=0001 for exactly 1 cycle; busy_o falls with grant.
- Round robin: req_i=1111 held high, all cnt=1.
  - Grants in order 0001, 0010, 0100, 1000, 0001; each lasts 40 cycles, with a 1-cycle IDLE gap between grants.
- Zero count: cnt2=0, req_i=0100.
  - grant_o=0100 for 20 cycles, led_o stays 0, then done_o=0100.
- Request withdrawal: req_i=0001 (cnt0=2) dropped 5 cycles after grant.
  - Full 60-cycle sequence completes; done_o=0001 is still issued.
- Reset mid-sequence: assert arst_i during the second ON phase.
  - All outputs are 0 in the same cycle, with no done_o.
  - After release, req_i=0010 is granted first when req 0 is idle.
- Idle beat, with and without the macro: no requests for 100 cycles.
  - Macro defined: led_o toggles every 20 cycles.
  - Macro undefined: led_o is constant 0.

Source files
------------

// File: rtl/led_blink_arbiter_if.sv
// Requester-side bundle for the shared status LED arbiter.
// Ports: req_i/blink_cnt_i flow from the requesters into the arbiter. grant_o/done_o/busy_o/led_o flow back out.
// master = requester/board side, slave = arbiter side.
interface led_blink_arbiter_if #(
    parameter int REQ_NUM   = 4,
    parameter int CNT_WIDTH = 4
);
    logic [REQ_NUM-1:0]           req_i;
    logic [REQ_NUM*CNT_WIDTH-1:0] blink_cnt_i;
    logic [REQ_NUM-1:0]           grant_o;
    logic [REQ_NUM-1:0]           done_o;
    logic                         busy_o;
    logic                         led_o;

    modport master (
        output req_i, blink_cnt_i,
        input  grant_o, done_o, busy_o, led_o
    );

    modport slave (
        input  req_i, blink_cnt_i,
        output grant_o, done_o, busy_o, led_o
    );
endinterface

// File: rtl/led_blink_arbiter.sv
// Round-robin share of one status LED: the granted requester gets N ON/OFF blinks followed by a trailing GAP.
// Latency: a request sampled at edge n drives grant/busy/led after edge n. done_o pulses one cycle after the final GAP tick.
// Backpressure: requesters hold req_i until done_o. Requests that are pending while a grant is active wait for the next IDLE scan.
// Ports: clk_i, arst_i (async, active high), plus bus (slave modport) carrying req_i, blink_cnt_i, grant_o, done_o, busy_o and led_o.
// Optional: define LED_BLINK_ARBITER_IDLE_BEAT_EN to make the LED toggle every GAP_TICKS ticks while idle.
module led_blink_arbiter #(
    parameter int CLK_VALUE = 100000000,
    parameter int TICK_HZ   = 10,
    parameter int REQ_NUM   = 4,
    parameter int CNT_WIDTH = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 6
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    led_blink_arbiter_if.slave   bus
);
    localparam int TICK_DIV  = CLK_VALUE / TICK_HZ;
    localparam int PSC_W     = $clog2(TICK_DIV);
    localparam int MAX_OF    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_TICKS = (MAX_OF > GAP_TICKS) ? MAX_OF : GAP_TICKS;
    localparam int TCNT_W    = $clog2(MAX_TICKS + 1);
    localparam int IDX_W     = $clog2(REQ_NUM);

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} state_t;

    state_t               state_q, state_d;
    logic [PSC_W-1:0]     psc_q, psc_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [REQ_NUM-1:0]   grant_q, grant_d;
    logic [REQ_NUM-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 led_q, led_d;

    logic [CNT_WIDTH-1:0] cnt_arr [REQ_NUM];
    logic                 tick;
    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand_idx;
    int                   cand;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_cnt
        assign cnt_arr[g] = bus.blink_cnt_i[g*CNT_WIDTH +: CNT_WIDTH];
    end

    assign tick = (psc_q == PSC_W'(TICK_DIV - 1));

    // Rotating priority: offsets are walked from farthest to nearest so the
    // requester just after last_q is the final (winning) assignment.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = REQ_NUM; i >= 1; i--) begin
            cand     = (int'(last_q) + i) % REQ_NUM;
            cand_idx = IDX_W'(cand);
            if (bus.req_i[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        psc_d   = tick ? '0 : psc_q + 1'b1;
        tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
        rem_d   = rem_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        led_d   = led_q;

        case (state_q)
            ST_IDLE: begin
`ifdef LED_BLINK_ARBITER_IDLE_BEAT_EN
                if (tick && tcnt_q == TCNT_W'(GAP_TICKS - 1)) begin
                    tcnt_d = '0;
                    led_d  = ~led_q;
                end
`else
                tcnt_d = '0;
                led_d  = 1'b0;
`endif
                if (win_vld) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                    busy_d           = 1'b1;
                    rem_d            = cnt_arr[win_idx];
                    psc_d            = '0;
                    tcnt_d           = '0;
                    // A zero count still owns the LED for one dark gap.
                    if (cnt_arr[win_idx] != '0) begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        led_d   = 1'b0;
                    end
                end
            end
            ST_ON: begin
                if (tick && tcnt_q == TCNT_W'(ON_TICKS - 1)) begin
                    rem_d   = rem_q - 1'b1;
                    led_d   = 1'b0;
                    state_d = ST_OFF;
                    psc_d   = '0;
                    tcnt_d  = '0;
                end
            end
            ST_OFF: begin
                if (tick && tcnt_q == TCNT_W'(OFF_TICKS - 1)) begin
                    psc_d  = '0;
                    tcnt_d = '0;
                    if (rem_q != '0) begin
                        state_d = ST_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tick && tcnt_q == TCNT_W'(GAP_TICKS - 1)) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    led_d   = 1'b0;
                    state_d = ST_IDLE;
                    psc_d   = '0;
                    tcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            psc_q   <= '0;
            tcnt_q  <= '0;
            rem_q   <= '0;
            last_q  <= IDX_W'(REQ_NUM - 1);
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            tcnt_q  <= tcnt_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign bus.grant_o = grant_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = busy_q;
    assign bus.led_o   = led_q;
endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: expected grant sequences are queued as requests are driven
// and retired by a monitor when done_o pulses.
module tb_led_blink_arbiter;
    localparam int CLK_VALUE = 100;
    localparam int TICK_HZ   = 10;
    localparam int TD        = CLK_VALUE / TICK_HZ;
    localparam int REQ_NUM   = 4;
    localparam int CNT_WIDTH = 4;
    localparam int ON_T      = 1;
    localparam int OFF_T     = 1;
    localparam int GAP_T     = 2;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_blink_arbiter_if #(.REQ_NUM(REQ_NUM), .CNT_WIDTH(CNT_WIDTH)) ifc ();

    led_blink_arbiter #(
        .CLK_VALUE(CLK_VALUE), .TICK_HZ(TICK_HZ), .REQ_NUM(REQ_NUM),
        .CNT_WIDTH(CNT_WIDTH), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .GAP_TICKS(GAP_T)
    ) u_dut (
        .clk_i (clk),
        .arst_i(arst),
        .bus   (ifc)
    );

    typedef struct {
        logic [REQ_NUM-1:0] grant;
        int                 n;
        int                 dur;
        int                 gap;   // required cycles from previous done to grant; 0 = not checked
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic expect_seq(input logic [REQ_NUM-1:0] g, input int n, input int gap);
        exp_t e;
        e.grant = g;
        e.n     = n;
        e.dur   = (n * (ON_T + OFF_T) + GAP_T) * TD;
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    bit                 in_seq    = 1'b0;
    int                 t_off     = 0;
    int                 led_err   = 0;
    int                 hold_err  = 0;
    int                 last_done = 0;
    int                 cur_n     = 0;
    int                 ph;
    logic               exp_led;
    logic [REQ_NUM-1:0] cur_grant;
    exp_t               ret;

    always @(negedge clk) begin
        if (arst || !mon_en) begin
            in_seq = 1'b0;
        end else begin
            if (!in_seq && ifc.grant_o != '0) begin
                in_seq    = 1'b1;
                t_off     = 0;
                led_err   = 0;
                hold_err  = 0;
                cur_grant = ifc.grant_o;
                if (sb_q.size() == 0) begin
                    chk("unexp_grant", ifc.grant_o, 0);
                    cur_n = 0;
                end else begin
                    chk("grant", ifc.grant_o, sb_q[0].grant);
                    chk("busy_on", ifc.busy_o, 1);
                    if (sb_q[0].gap != 0) chk("arb_gap", cyc - last_done, sb_q[0].gap);
                    cur_n = sb_q[0].n;
                end
            end
            if (in_seq && ifc.grant_o != '0) begin
                ph      = t_off / TD;
                exp_led = (ph < cur_n * (ON_T + OFF_T)) && ((ph % (ON_T + OFF_T)) < ON_T);
                if (ifc.led_o !== exp_led) led_err++;
                if (ifc.grant_o !== cur_grant || ifc.busy_o !== 1'b1) hold_err++;
                t_off++;
            end
            if (ifc.done_o != '0) begin
                if (!in_seq || sb_q.size() == 0) begin
                    chk("unexp_done", ifc.done_o, 0);
                end else begin
                    ret = sb_q.pop_front();
                    chk("done", ifc.done_o, ret.grant);
                    chk("grant_len", t_off, ret.dur);
                    chk("led_pattern", led_err, 0);
                    chk("grant_hold", hold_err, 0);
                    chk("grant_off", ifc.grant_o, 0);
                    chk("busy_off", ifc.busy_o, 0);
                end
                last_done = cyc;
                in_seq    = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input int budget);
        int k = 0;
        @(negedge clk);
        while (k < budget && ifc.done_o == '0) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", ifc.done_o != '0, 1);
    endtask

    task automatic wait_grant(input int budget);
        int k = 0;
        @(negedge clk);
        while (k < budget && ifc.grant_o == '0) begin
            @(negedge clk);
            k++;
        end
        chk("grant_seen", ifc.grant_o != '0, 1);
    endtask

    task automatic pulse_reset();
        arst = 1'b1;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        int hi;
        ifc.req_i       = '0;
        ifc.blink_cnt_i = '0;
        arst            = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant", ifc.grant_o, 0);
        chk("rst_done", ifc.done_o, 0);
        chk("rst_busy", ifc.busy_o, 0);
        chk("rst_led", ifc.led_o, 0);
        arst = 1'b0;
        @(negedge clk);

        // single request, three blinks
        ifc.blink_cnt_i = 16'h0003;
        ifc.req_i       = 4'b0001;
        expect_seq(4'b0001, 3, 0);
        wait_done(200);
        ifc.req_i = '0;
        @(negedge clk);
        chk("done_width", ifc.done_o, 0);
        chk("busy_idle", ifc.busy_o, 0);

        // round robin from a fresh pointer, everyone requesting
        pulse_reset();
        ifc.blink_cnt_i = 16'h1111;
        ifc.req_i       = 4'b1111;
        expect_seq(4'b0001, 1, 0);
        expect_seq(4'b0010, 1, 1);
        expect_seq(4'b0100, 1, 1);
        expect_seq(4'b1000, 1, 1);
        expect_seq(4'b0001, 1, 1);
        for (int i = 0; i < 5; i++) wait_done(100);
        ifc.req_i = '0;
        @(negedge clk);

        // zero blink count: only the dark gap
        ifc.blink_cnt_i = 16'h1011;
        ifc.req_i       = 4'b0100;
        expect_seq(4'b0100, 0, 0);
        wait_done(100);
        ifc.req_i = '0;
        @(negedge clk);

        // request withdrawn mid-sequence, count changed after grant
        ifc.blink_cnt_i = 16'h0002;
        ifc.req_i       = 4'b0001;
        expect_seq(4'b0001, 2, 0);
        wait_grant(50);
        repeat (5) @(negedge clk);
        ifc.req_i       = '0;
        ifc.blink_cnt_i = 16'h000F;
        wait_done(200);
        @(negedge clk);

        // reset in the second ON phase
        mon_en          = 1'b0;
        ifc.blink_cnt_i = 16'h0002;
        ifc.req_i       = 4'b0001;
        wait_grant(50);
        repeat (24) @(negedge clk);
        chk("on2_led", ifc.led_o, 1);
        #2 arst = 1'b1;
        #1;
        chk("mid_rst_grant", ifc.grant_o, 0);
        chk("mid_rst_busy", ifc.busy_o, 0);
        chk("mid_rst_led", ifc.led_o, 0);
        chk("mid_rst_done", ifc.done_o, 0);
        ifc.req_i = '0;
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifc.done_o != '0) dcnt++;
        end
        arst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ifc.done_o != '0 || ifc.grant_o != '0) dcnt++;
        end
        chk("no_done_after_rst", dcnt, 0);
        mon_en          = 1'b1;
        ifc.blink_cnt_i = 16'h0010;
        ifc.req_i       = 4'b0010;
        expect_seq(4'b0010, 1, 0);
        wait_done(100);
        ifc.req_i = '0;
        @(negedge clk);

        // idle behaviour of the LED
`ifdef LED_BLINK_ARBITER_IDLE_BEAT_EN
        begin
            logic prev;
            int   last_t;
            int   ntog;
            int   bad;
            prev   = ifc.led_o;
            last_t = -1;
            ntog   = 0;
            bad    = 0;
            repeat (120) begin
                @(negedge clk);
                if (ifc.led_o !== prev) begin
                    ntog++;
                    if (last_t >= 0 && cyc - last_t != 2 * TD) bad++;
                    last_t = cyc;
                    prev   = ifc.led_o;
                end
            end
            chk("beat_toggles", ntog >= 5, 1);
            chk("beat_period", bad, 0);
        end
`else
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifc.led_o !== 1'b0) hi++;
        end
        chk("idle_led_dark", hi, 0);
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
